mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Parametrised, synthesizable memory responder for the picorv32 native memory interface (mem_valid/mem_ready), used by formal and simulation benches in place of ad-hoc inline memory arrays.
- Provides bounded, solver-driven or fixed-latency wait states, byte-strobed writes and out-of-range handling.
- Includes a sticky protocol checker the bench can assert on.
- Sits directly between the bench's free inputs and the CPU's memory port.

Parameters:
ADDR_BITS, 10, word-index width; memory holds 2**ADDR_BITS 32-bit words
MAX_STALL, 3, MODE 0 only: maximum extra wait cycles per transaction (0..15)
MODE, 0, 0 = stall_req-driven bounded stalls; 1 = fixed latency
FIXED_LAT, 2, MODE 1 only: cycles spent in WAIT (1..16)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_req  input  1  free stall request (MODE 0); ignored in MODE 1
mem_valid  input  1  CPU request valid
mem_instr  input  1  CPU instruction-fetch flag
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write strobes; 0 = read
mem_ready  output  1  registered one-cycle response strobe
mem_rdata  output  32  registered read data, valid while mem_ready=1
proto_err  output  1  sticky: protocol violation seen
oob_err  output  1  sticky: out-of-range access seen
txn_count  output  32  completed transactions, wraps at 2**32

Behaviour:
- Reset (synchronous, active-high): next edge forces state IDLE, mem_ready=0, mem_rdata=0, proto_err=0, oob_err=0, txn_count=0, stall counter=0. Memory contents are NOT cleared. An in-flight transaction is dropped; its write is never performed.
- States: IDLE, WAIT, RESP.
- IDLE: when mem_valid=1, latch addr/wdata/wstrb/instr, clear stall counter, go to WAIT.
- WAIT, MODE 0: if stall_req=0 or counter==MAX_STALL, go to RESP; otherwise increment the counter and stay. MAX_STALL=0 means no stalls.
- WAIT, MODE 1: stay until the counter reaches FIXED_LAT-1, then go to RESP.
- RESP: mem_ready=1 for exactly one cycle, then go to IDLE and increment txn_count.
  - mem_rdata holds the word at the latched index, read before any write from this transaction.
  - Writes to the latched word use the latched strobes, byte-wise, and commit on the edge leaving RESP.
- Latency: mem_valid sampled at edge N gives mem_ready high in the cycle after edge N+1+stalls. Minimum 2 cycles; maximum 2+MAX_STALL cycles (MODE 0) or 1+FIXED_LAT cycles (MODE 1).
- mem_ready is 0 in IDLE and WAIT, and whenever the state is not RESP.
- mem_rdata is held when mem_ready=0.
- Out of range: latched mem_addr[31:ADDR_BITS+2] != 0. The read returns 0, the write is suppressed, oob_err is set at the RESP edge, and the transaction still completes normally.
- proto_err is set (sticky until reset) on any of:
  - mem_valid=0 during WAIT or RESP;
  - mem_addr, mem_wdata, mem_wstrb or mem_instr differing from latched values during WAIT or RESP;
  - mem_instr=1 with mem_wstrb!=0 when latched;
  - mem_addr[1:0]!=0 when latched.
  After a violation the FSM continues using the latched values.
- mem_valid=1 in the IDLE cycle right after RESP is a new request; it is not an error.

Test Plan:
- Reset hold, then release with mem_valid=0 -> mem_ready=0, txn_count=0, proto_err=0, oob_err=0 for 10 cycles.
- MODE 0, MAX_STALL=3, stall_req=1 constant: write 0xDEADBEEF with wstrb=0xF to addr 0x10, then read 0x10 -> each mem_ready arrives exactly 5 cycles after mem_valid rises; read returns 0xDEADBEEF; txn_count=2.
- Byte strobes: word at 0x20 = 0x11223344; write 0xAABBCCDD with wstrb=0x5 -> later read returns 0x11BB33DD.
- MODE 1, FIXED_LAT=3: read -> mem_ready high exactly 4 cycles after mem_valid, for 1 cycle.
- Out of range with ADDR_BITS=10: write to 0x00001000 -> completes, oob_err=1, word 0 unchanged. Read of 0x00001000 returns 0.
- Violations:
  - mem_addr changes 0x10 -> 0x14 during WAIT -> proto_err=1 next cycle, response uses 0x10.
  - Reset asserted in WAIT of a write -> next cycle IDLE, proto_err=0, target word unchanged.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// ============================================================================
// Module      : mem_bus_responder_if
// Description : picorv32 native memory bus bundle (valid/ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module      : mem_bus_responder
// Description : Word memory answering picorv32 requests with bounded or fixed
//               wait states, byte strobes, range and protocol error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder #(
    parameter int ADDR_BITS = 10,
    parameter int MAX_STALL = 3,
    parameter int MODE      = 0,
    parameter int FIXED_LAT = 2
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                stall_req,
    mem_bus_responder_if.slave       bus,
    output logic                     proto_err,
    output logic                     oob_err,
    output logic [31:0]              txn_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [4:0] c_STALL_MAX = 5'(MAX_STALL);
    localparam logic [4:0] c_LAT_LAST  = 5'(FIXED_LAT - 1);
    localparam int         c_DEPTH     = 2 ** ADDR_BITS;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        proto_q, proto_d;
    logic        oob_q, oob_d;
    logic [31:0] txn_q, txn_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    logic [31:0] mem_q [c_DEPTH];

    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_oob;
    logic                 w_latch;
    logic                 w_viol;

    assign w_idx   = addr_q[ADDR_BITS+1:2];
    // Any address bit above the word index puts the access out of range.
    assign w_oob   = (addr_q >> (ADDR_BITS + 2)) != 32'd0;
    assign w_latch = (state_q == c_ST_IDLE) && bus.mem_valid;

    // ------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= 5'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            proto_q <= 1'b0;
            oob_q   <= 1'b0;
            txn_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            proto_q <= proto_d;
            oob_q   <= oob_d;
            txn_q   <= txn_d;
        end
    end

    // Request capture needs no reset: it is only consumed after a latch.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            instr_q <= bus.mem_instr;
        end
    end

    // Write commits on the edge leaving RESP; a reset there drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == c_ST_RESP) && !w_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.mem_valid) begin
                    state_d = c_ST_WAIT;
                    cnt_d   = 5'd0;
                end
            end
            c_ST_WAIT: begin
                if (MODE == 1) begin
                    if (cnt_q == c_LAT_LAST) begin
                        state_d = c_ST_RESP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    if (!stall_req || (cnt_q == c_STALL_MAX)) begin
                        state_d = c_ST_RESP;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            c_ST_RESP: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and status logic
    // ------------------------------------------------------------------
    always_comb begin
        w_viol = 1'b0;
        if (w_latch) begin
            w_viol = (bus.mem_instr && (bus.mem_wstrb != 4'd0))
                   || (bus.mem_addr[1:0] != 2'b00);
        end else if ((state_q == c_ST_WAIT) || (state_q == c_ST_RESP)) begin
            w_viol = !bus.mem_valid
                   || (bus.mem_addr  != addr_q)
                   || (bus.mem_wdata != wdata_q)
                   || (bus.mem_wstrb != wstrb_q)
                   || (bus.mem_instr != instr_q);
        end
    end

    always_comb begin
        ready_d = (state_d == c_ST_RESP);
        rdata_d = rdata_q;
        proto_d = proto_q | w_viol;
        oob_d   = oob_q;
        txn_d   = txn_q;
        // Read is sampled entering RESP, ahead of this transaction's write.
        if ((state_q == c_ST_WAIT) && (state_d == c_ST_RESP)) begin
            rdata_d = w_oob ? 32'd0 : mem_q[w_idx];
        end
        if (state_q == c_ST_RESP) begin
            txn_d = txn_q + 32'd1;
            if (w_oob) begin
                oob_d = 1'b1;
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign proto_err     = proto_q;
    assign oob_err       = oob_q;
    assign txn_count     = txn_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================================
// Module      : tb_mem_bus_responder
// Description : Directed self-checking bench for mem_bus_responder, covering
//               a stalling instance (MODE 0) and a fixed-latency one (MODE 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_responder;

    logic        clk;
    logic        reset;
    logic        stall0;
    logic        stall1;
    logic        proto0, oob0, proto1, oob1;
    logic [31:0] txn0, txn1;

    int n_chk;
    int n_pass;

    mem_bus_responder_if bus0 ();
    mem_bus_responder_if bus1 ();

    mem_bus_responder #(
        .ADDR_BITS (10),
        .MAX_STALL (3),
        .MODE      (0),
        .FIXED_LAT (2)
    ) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .stall_req (stall0),
        .bus       (bus0),
        .proto_err (proto0),
        .oob_err   (oob0),
        .txn_count (txn0)
    );

    mem_bus_responder #(
        .ADDR_BITS (10),
        .MAX_STALL (3),
        .MODE      (1),
        .FIXED_LAT (3)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .stall_req (stall1),
        .bus       (bus1),
        .proto_err (proto1),
        .oob_err   (oob1),
        .txn_count (txn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic ins,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (sel) begin
            bus1.mem_valid = v; bus1.mem_instr = ins; bus1.mem_addr = a;
            bus1.mem_wdata = d; bus1.mem_wstrb = s;
        end else begin
            bus0.mem_valid = v; bus0.mem_instr = ins; bus0.mem_addr = a;
            bus0.mem_wdata = d; bus0.mem_wstrb = s;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus1.mem_ready : bus0.mem_ready;
    endfunction

    function automatic logic [31:0] rdat(input bit sel);
        return sel ? bus1.mem_rdata : bus0.mem_rdata;
    endfunction

    // Holds the request until the edge that retires RESP, like the CPU does.
    task automatic txn(input bit sel, input logic ins, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, ins, a, d, s);
        lat = 0;
        rd  = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rdy(sel)) begin
                rd = rdat(sel);
                break;
            end
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        stall0 = 1'b1;
        stall1 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus0.mem_ready}, 32'd0);
            chk("idle_txn",   txn0, 32'd0);
            chk("idle_proto", {31'd0, proto0}, 32'd0);
            chk("idle_oob",   {31'd0, oob0}, 32'd0);
        end
        chk("idle_ready1", {31'd0, bus1.mem_ready}, 32'd0);

        // Fixed latency instance: ready 4 cycles after valid, single cycle.
        txn(1'b1, 1'b0, 32'h8, 32'h0000_CAFE, 4'hF, rd, lat);
        chk("m1_wr_lat", 32'(lat), 32'd4);
        txn(1'b1, 1'b0, 32'h8, 32'd0, 4'h0, rd, lat);
        chk("m1_rd_lat",  32'(lat), 32'd4);
        chk("m1_rd_data", rd, 32'h0000_CAFE);
        @(negedge clk);
        chk("m1_ready_once", {31'd0, bus1.mem_ready}, 32'd0);
        chk("m1_rdata_hold", bus1.mem_rdata, 32'h0000_CAFE);
        chk("m1_txn", txn1, 32'd2);

        // Full-stall write and read back.
        txn(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, lat);
        chk("wr_lat", 32'(lat), 32'd5);
        txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd, lat);
        chk("rd_lat",  32'(lat), 32'd5);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("txn_two", txn0, 32'd2);

        // Byte strobes.
        txn(1'b0, 1'b0, 32'h20, 32'h1122_3344, 4'hF, rd, lat);
        txn(1'b0, 1'b0, 32'h20, 32'hAABB_CCDD, 4'h5, rd, lat);
        txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, rd, lat);
        chk("strb_data", rd, 32'h11BB_33DD);
        @(negedge clk);
        chk("rdata_hold", bus0.mem_rdata, 32'h11BB_33DD);

        // No stall request: minimum latency.
        stall0 = 1'b0;
        txn(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, rd, lat);
        chk("min_lat",  32'(lat), 32'd2);
        chk("min_data", rd, 32'h11BB_33DD);
        stall0 = 1'b1;
        chk("clean_proto", {31'd0, proto0}, 32'd0);
        chk("txn_six", txn0, 32'd6);

        // Out of range.
        txn(1'b0, 1'b0, 32'h0, 32'h0BAD_F00D, 4'hF, rd, lat);
        chk("oob_clear", {31'd0, oob0}, 32'd0);
        txn(1'b0, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, rd, lat);
        chk("oob_wr_lat", 32'(lat), 32'd5);
        chk("oob_set",    {31'd0, oob0}, 32'd1);
        chk("oob_txn",    txn0, 32'd8);
        txn(1'b0, 1'b0, 32'h0, 32'd0, 4'h0, rd, lat);
        chk("oob_word0", rd, 32'h0BAD_F00D);
        txn(1'b0, 1'b0, 32'h0000_1000, 32'd0, 4'h0, rd, lat);
        chk("oob_rd", rd, 32'd0);

        // Address changes mid-transaction; memory survives reset.
        pulse_reset();
        chk("rst_oob", {31'd0, oob0}, 32'd0);
        chk("rst_txn", txn0, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
        @(negedge clk);
        chk("viol_pre", {31'd0, proto0}, 32'd0);
        bus0.mem_addr = 32'h14;
        @(negedge clk);
        chk("viol_set", {31'd0, proto0}, 32'd1);
        rd = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            if (bus0.mem_ready) begin
                rd = bus0.mem_rdata;
                break;
            end
            @(negedge clk);
        end
        chk("viol_data", rd, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset during WAIT of a write drops it.
        pulse_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h1234_5678, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_proto", {31'd0, proto0}, 32'd0);
        chk("rstw_ready", {31'd0, bus0.mem_ready}, 32'd0);
        txn(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, rd, lat);
        chk("rstw_data", rd, 32'hDEAD_BEEF);
        chk("rstw_lat",  32'(lat), 32'd5);
        chk("rstw_txn",  txn0, 32'd1);

        // Misaligned address and instruction fetch with strobes.
        txn(1'b0, 1'b0, 32'h22, 32'd0, 4'h0, rd, lat);
        chk("misalign", {31'd0, proto0}, 32'd1);
        pulse_reset();
        txn(1'b0, 1'b1, 32'h30, 32'h5555_5555, 4'h1, rd, lat);
        chk("instr_wstrb", {31'd0, proto0}, 32'd1);
        chk("instr_txn",   txn0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
